// File: rtl/key_schedule_gen.sv
// Sequential round-key expansion engine with a nibble S-box and a registered read port.
// Optional macro KEYGEN_SBOX_REG_EN adds a SUB state that registers the S-box output (2 cycles per round).
module key_schedule_gen #(
  parameter  int WORDS  = 4,
  parameter  int ROUNDS = 2,
  localparam int KW     = 4 * WORDS,
  localparam int IDX_W  = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [KW-1:0]    key,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KW-1:0]    rd_key
);

`ifdef KEYGEN_SBOX_REG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_MIX = 2'd2, S_DONE = 2'd3} state_t;
  localparam state_t S_ROUND = S_SUB;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MIX = 2'd2, S_DONE = 2'd3} state_t;
  localparam state_t S_ROUND = S_MIX;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;
      4'h1: sbox = 4'h4;
      4'h2: sbox = 4'hD;
      4'h3: sbox = 4'h1;
      4'h4: sbox = 4'h2;
      4'h5: sbox = 4'hF;
      4'h6: sbox = 4'hB;
      4'h7: sbox = 4'h8;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hA;
      4'hA: sbox = 4'h6;
      4'hB: sbox = 4'hC;
      4'hC: sbox = 4'h5;
      4'hD: sbox = 4'h9;
      4'hE: sbox = 4'h0;
      4'hF: sbox = 4'h7;
      default: sbox = 4'h0;
    endcase
  endfunction

  // Nibble 0 sits in the MSBs; each later nibble chains off the freshly computed one.
  function automatic logic [KW-1:0] round_fn(input logic [KW-1:0] k, input logic [3:0] s,
                                             input logic [3:0] rc);
    logic [KW-1:0] res;
    logic [3:0]    prev;
    res  = '0;
    prev = k[KW-1 -: 4] ^ s ^ rc;
    res[KW-1 -: 4] = prev;
    for (int j = 1; j < WORDS; j++) begin
      prev = k[KW-1-4*j -: 4] ^ prev;
      res[KW-1-4*j -: 4] = prev;
    end
    return res;
  endfunction

  state_t           r_state;
  logic [KW-1:0]    r_buf [0:ROUNDS];
  logic [KW-1:0]    r_work;
  logic [IDX_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [KW-1:0]    r_rd_key;
  logic [3:0]       w_sub;
  logic [KW-1:0]    w_next;

`ifdef KEYGEN_SBOX_REG_EN
  logic [3:0] r_sub;
  assign w_sub = r_sub;
`else
  assign w_sub = sbox(r_work[3:0]);
`endif

  assign w_next = round_fn(r_work, w_sub, 4'(r_cnt));

  // Expansion FSM, working key, round counter and round-key buffer.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_work  <= '0;
`ifdef KEYGEN_SBOX_REG_EN
      r_sub   <= 4'h0;
`endif
      for (int i = 0; i <= ROUNDS; i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i <= ROUNDS; i++) r_buf[i] <= '0;
            r_buf[0] <= key;
            r_work   <= key;
            r_cnt    <= IDX_W'(1);
            r_valid  <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_ROUND;
          end
        end
`ifdef KEYGEN_SBOX_REG_EN
        S_SUB: begin
          r_sub   <= sbox(r_work[3:0]);
          r_state <= S_MIX;
        end
`endif
        S_MIX: begin
          r_buf[r_cnt] <= w_next;
          r_work       <= w_next;
          if (r_cnt == IDX_W'(ROUNDS)) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + IDX_W'(1);
            r_state <= S_ROUND;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered read port; indices past the last round read as zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rd_key <= '0;
    end else if (rd_idx <= IDX_W'(ROUNDS)) begin
      r_rd_key <= r_buf[rd_idx];
    end else begin
      r_rd_key <= '0;
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign valid  = r_valid;
  assign rd_key = r_rd_key;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen: directed scenarios plus random keys
// against a nibble-array reference model of the key schedule and buffer timing.
module tb_key_schedule_gen;
  localparam int WORDS  = 4;
  localparam int ROUNDS = 2;
  localparam int KW     = 4 * WORDS;
  localparam int IDX_W  = $clog2(ROUNDS + 1);
`ifdef KEYGEN_SBOX_REG_EN
  localparam int CYC = 2;
`else
  localparam int CYC = 1;
`endif
  localparam int LAST = CYC * ROUNDS + 1;
  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                       4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};

  logic             clk = 1'b0;
  logic             nrst;
  logic             start;
  logic [KW-1:0]    key;
  logic             ready, busy, done, valid;
  logic [IDX_W-1:0] rd_idx;
  logic [KW-1:0]    rd_key;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [KW-1:0] mrk  [0:ROUNDS];
  logic [KW-1:0] mbuf [0:ROUNDS];

  key_schedule_gen #(.WORDS(WORDS), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .nrst(nrst), .start(start), .key(key),
    .ready(ready), .busy(busy), .done(done), .valid(valid),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference schedule computed directly on an array of nibbles.
  task automatic expand(input logic [KW-1:0] k);
    logic [3:0] nib [WORDS];
    for (int j = 0; j < WORDS; j++) nib[j] = k[4*(WORDS-1-j) +: 4];
    mrk[0] = k;
    for (int i = 1; i <= ROUNDS; i++) begin
      nib[0] = nib[0] ^ SBOX[nib[WORDS-1]] ^ 4'(i);
      for (int j = 1; j < WORDS; j++) nib[j] = nib[j] ^ nib[j-1];
      for (int j = 0; j < WORDS; j++) mrk[i][4*(WORDS-1-j) +: 4] = nib[j];
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_valid);
    check({tag, "_ready"}, 64'(ready), 64'(1'b1));
    check({tag, "_busy"},  64'(busy),  64'(1'b0));
    check({tag, "_done"},  64'(done),  64'(1'b0));
    check({tag, "_valid"}, 64'(valid), 64'(exp_valid));
  endtask

  task automatic read_check(input string tag, input int idx, input logic [KW-1:0] exp);
    rd_idx = IDX_W'(idx);
    tick;
    check(tag, 64'(rd_key), 64'(exp));
  endtask

  task automatic do_reset;
    nrst  = 1'b0;
    start = 1'b0;
    tick;
    tick;
    nrst = 1'b1;
    for (int i = 0; i <= ROUNDS; i++) mbuf[i] = '0;
  endtask

  // Start an expansion and follow it cycle by cycle up to and including the done pulse.
  task automatic run(input logic [KW-1:0] k, input bit hold);
    expand(k);
    key   = k;
    start = 1'b1;
    for (int n = 0; n <= LAST; n++) begin
      logic [KW-1:0] exp_rd;
      rd_idx = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      exp_rd = (int'(rd_idx) <= ROUNDS) ? mbuf[rd_idx] : '0;
      tick;
      check("rd_sweep", 64'(rd_key), 64'(exp_rd));
      if (n == 0) begin
        for (int i = 0; i <= ROUNDS; i++) mbuf[i] = '0;
        mbuf[0] = k;
      end else if ((n % CYC) == 0 && (n / CYC) <= ROUNDS) begin
        mbuf[n / CYC] = mrk[n / CYC];
      end
      check("busy",  64'(busy),  64'(n < LAST));
      check("ready", 64'(ready), 64'(n == LAST));
      check("done",  64'(done),  64'(n == LAST));
      check("valid", 64'(valid), 64'(n == LAST));
      start = (hold && n < LAST) ? 1'b1 : 1'b0;
      if (hold) key = KW'($urandom);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i <= ROUNDS; i++) read_check(tag, i, mrk[i]);
    read_check({tag, "_oob"}, ROUNDS + 1, '0);
    check_idle(tag, 1'b1);
  endtask

  initial begin
    nrst   = 1'b0;
    start  = 1'b0;
    key    = '0;
    rd_idx = '0;
    do_reset;
    check_idle("reset", 1'b0);
    check("reset_rd_key", 64'(rd_key), 64'(0));
    for (int i = 0; i <= ROUNDS + 1; i++) read_check("reset_read", i, '0);

    run(16'h2D55, 1'b0);
    read_check("rk0_2d55", 0, 16'h2D55);
    read_check("rk1_2d55", 1, 16'hC141);
    read_check("rk2_2d55", 2, 16'hABFE);
    read_check("rk3_oob",  3, 16'h0000);
    check_idle("after_2d55", 1'b1);

    run(16'h0000, 1'b0);
    read_check("rk1_0000", 1, 16'hFFFF);
    read_check("rk2_0000", 2, 16'hA5A5);
    read_all("zero_key");

    run(16'h2D55, 1'b1);
    read_check("hold_rk0", 0, 16'h2D55);
    read_check("hold_rk1", 1, 16'hC141);
    read_check("hold_rk2", 2, 16'hABFE);

    // Reset right after RK1 lands, then restart from a zero key.
    key   = 16'h2D55;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 0; n < CYC; n++) tick;
    do_reset;
    check_idle("midreset", 1'b0);
    for (int i = 0; i <= ROUNDS; i++) read_check("midreset_read", i, '0);
    run(16'h0000, 1'b0);
    read_check("restart_rk0", 0, 16'h0000);
    read_check("restart_rk1", 1, 16'hFFFF);
    read_check("restart_rk2", 2, 16'hA5A5);

    // Back-to-back: second start lands in the cycle done is high.
    run(KW'($urandom), 1'b0);
    run(KW'($urandom), 1'b0);
    read_all("back_to_back");

    for (int t = 0; t < 6; t++) begin
      run(KW'($urandom), t[0]);
      read_all("random_key");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_schedule_gen.md
# key_schedule_gen

Parametrised key-expansion engine for the nibble-oriented AES datapath. It accepts a cipher key, generates every round key (RK0..RK(ROUNDS)) sequentially with an FSM and a nibble S-box, and holds them in an internal round-key buffer. The round function reads that buffer through a registered random-access port. It supersedes the single-round key generator: key width, round count and S-box pipelining are configurable, and it adds a start/ready/done handshake.

## Interface
- WORDS, 4: nibbles per key; key width KW = 4*WORDS; legal WORDS ≥ 2
- ROUNDS, 2: round keys generated after RK0; legal 1..15
- IDX_W (localparam) = $clog2(ROUNDS+1)
- clk  in  1  rising-edge clock
- nrst  in  1  synchronous, active-low reset
- start  in  1  request expansion; accepted only when ready=1
- key  in  KW  cipher key, sampled on the accepting edge
- ready  out  1  idle, start will be accepted
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse after the last round key is written
- valid  out  1  level: buffer holds a complete schedule for the last accepted key
- rd_idx  in  IDX_W  round-key index to read
- rd_key  out  KW  registered read data

## Operation
- Nibble order: w[0] = key[KW-1:KW-4] (MSB nibble) … w[WORDS-1] = key[3:0].
- Round i (1..ROUNDS), from previous key w to new key w':
  - w'[0] = w[0] ^ S(w[WORDS-1]) ^ rcon_i, where rcon_i = i[3:0]
  - w'[j] = w[j] ^ w'[j-1] for j = 1..WORDS-1
- S-box S (in→out, hex): 0→E 1→4 2→D 3→1 4→2 5→F 6→B 7→8 8→3 9→A A→6 B→C C→5 D→9 E→0 F→7.
- FSM states: IDLE, SUB (only when KEYGEN_SBOX_REG_EN is defined), MIX, DONE.
  - IDLE: ready=1. On start, clear all buffer entries, write key to entry 0, load the working register, set round counter to 1, clear valid, and go to MIX (or SUB).
  - MIX: compute w', write it to entry[counter] and to the working register. If counter==ROUNDS, go to DONE; otherwise increment counter and go to MIX (or SUB).
  - DONE: assert done for one cycle, set valid, return to IDLE.
- start while busy is ignored and has no effect on the running expansion.
- Read port: rd_key <= entry[rd_idx] on each edge. For rd_idx > ROUNDS, rd_key <= 0. Unwritten entries read 0.
- All arithmetic is bitwise XOR on 4-bit nibbles. rcon_i is truncated to 4 bits.

## Timing
- Reset values: ready=1, busy=0, done=0, valid=0, rd_key=0, all buffer entries 0, FSM=IDLE.
- Accepting edge T writes RK0. Without the macro, RKi is written at edge T+i. done is high for the cycle after edge T+ROUNDS+1. valid rises at that same edge.
- busy=1 and ready=0 from edge T to the edge at which done is asserted. ready returns 1 together with done.
- Read latency is 1 cycle. A read of an entry on the same edge that entry is written returns the old contents.
- If nrst=0 at any edge, including mid-expansion, every register returns to its reset value on that edge. A partial schedule is discarded.
- A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted, and valid drops on that edge.

## Configuration
- KEYGEN_SBOX_REG_EN defined:
  - S(w[WORDS-1]) is registered in the SUB state; MIX uses the registered value.
  - Each round takes 2 cycles, so RKi is written at edge T+2i and done follows edge T+2*ROUNDS+1.
- KEYGEN_SBOX_REG_EN undefined: the S-box is combinational, there is no SUB state, and each round takes 1 cycle.
- Round-key values are identical in both builds.

## Test plan
- Reset (nrst=0 for 2 cycles) -> ready=1, busy=0, valid=0, done=0. Reading rd_idx=0..ROUNDS gives rd_key=0.
- WORDS=4, ROUNDS=2, key=16'h2D55, start -> RK0=2D55, RK1=C141, RK2=ABFE. done pulses once, valid=1.
- key=16'h0000 -> RK1=FFFF, RK2=A5A5. Check done timing in both macro builds: T+3 without the macro, T+5 with it.
- start re-asserted every cycle during expansion -> schedule unchanged (2D55/C141/ABFE) and exactly one done pulse.
- nrst=0 right after RK1 is written, then a new start with 0000 -> the old entries read 0 before the restart, and the final schedule is 0000/FFFF/A5A5.
- rd_idx=3 with ROUNDS=2 -> rd_key=0. Sweep rd_idx during generation -> unwritten entries read 0, and data appears 1 cycle after each write.
